// File: rtl/act_lut_loader_pkg.sv
// Shared constants and FSM state type for the activation LUT loader and its
// interpolation pipeline.
package act_lut_loader_pkg;
   localparam int DATA_W    = 8;
   localparam int SEG_BITS  = 4;
   localparam int N_ENTRIES = (2 ** SEG_BITS) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } act_state_e;
endpackage

// File: rtl/act_lut_loader_interp_pipe.sv
// Two-stage piecewise-linear interpolation: stage 1 holds base/slope/fraction,
// stage 2 holds the interpolated activation.
module act_interp_pipe
   import act_lut_loader_pkg::*;
#(
   parameter int DATA_W = act_lut_loader_pkg::DATA_W,
   parameter int FRAC_W = act_lut_loader_pkg::DATA_W - act_lut_loader_pkg::SEG_BITS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   input  logic signed [DATA_W-1:0] base_i,
   input  logic signed [DATA_W-1:0] next_i,
   input  logic        [FRAC_W-1:0] frac_i,
   output logic                     out_valid_o,
   output logic signed [DATA_W-1:0] a_o
);
   localparam int DIFF_W = DATA_W + 1;
   localparam int PROD_W = DIFF_W + FRAC_W + 1;

   logic                     s1_valid_q;
   logic signed [DATA_W-1:0] base_q;
   logic signed [DIFF_W-1:0] diff_q, diff_d;
   logic        [FRAC_W-1:0] frac_q;
   logic signed [PROD_W-1:0] prod;
   logic signed [DATA_W-1:0] a_q, a_d;
   logic                     out_valid_q;

   assign diff_d = $signed({next_i[DATA_W-1], next_i}) - $signed({base_i[DATA_W-1], base_i});
   assign prod   = diff_q * $signed({1'b0, frac_q});
   // the true result always lies between base and next, so truncation is exact
   assign a_d    = base_q + DATA_W'(prod >>> FRAC_W);

   always_ff @(posedge clk) begin
      if (in_valid_i) begin
         base_q <= base_i;
         diff_q <= diff_d;
         frac_q <= frac_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         a_q         <= '0;
      end else if (flush_i) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         s1_valid_q  <= in_valid_i;
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            a_q <= a_d;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign a_o         = a_q;
endmodule

// File: rtl/act_lut_loader.sv
// Activation LUT: streams 2**SEG_BITS+1 signed entries into a table, then
// serves interpolated lookups through a 2-stage pipeline.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no usable table (after reset or a failed load)
//   ST_LOAD  | accepting write beats, wr_ready high
//   ST_READY | table complete, lookups enabled
module act_lut_loader
   import act_lut_loader_pkg::*;
#(
   parameter int DATA_W   = act_lut_loader_pkg::DATA_W,
   parameter int SEG_BITS = act_lut_loader_pkg::SEG_BITS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load_start,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic                     wr_last,
   output logic                     load_done,
   output logic                     load_err,
   output logic                     table_valid,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] z__value,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] a
);
   localparam int FRAC_W  = DATA_W - SEG_BITS;
   localparam int IDX_W   = SEG_BITS + 1;
   localparam int NUM_ENT = (2 ** SEG_BITS) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 ** SEG_BITS);

   act_state_e               state_q, state_d;
   logic [IDX_W-1:0]         count_q, count_d;
   logic                     table_valid_q, table_valid_d;
   logic                     load_err_q, load_err_d;
   logic                     load_done_q, load_done_d;
   logic signed [DATA_W-1:0] entry_q [NUM_ENT];

   logic                     wr_fire;
   logic                     entry_we;
   logic [IDX_W-1:0]         seg_idx;
   logic [IDX_W-1:0]         seg_idx_nxt;
   logic [FRAC_W-1:0]        frac;
   logic                     lookup_fire;

   assign wr_ready = (state_q == ST_LOAD);
   assign wr_fire  = wr_ready && wr_valid;
   // a beat coinciding with load_start or reset is dropped
   assign entry_we = wr_fire && !load_start && rst_n;

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      table_valid_d = table_valid_q;
      load_err_d    = load_err_q;
      load_done_d   = 1'b0;
      if (load_start) begin
         state_d       = ST_LOAD;
         count_d       = '0;
         table_valid_d = 1'b0;
         load_err_d    = 1'b0;
      end else if (wr_fire) begin
         if ((count_q == LAST_IDX) && wr_last) begin
            state_d       = ST_READY;
            table_valid_d = 1'b1;
            load_done_d   = 1'b1;
         end else if ((count_q == LAST_IDX) || wr_last) begin
            state_d       = ST_IDLE;
            table_valid_d = 1'b0;
            load_err_d    = 1'b1;
         end else begin
            count_d = count_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         count_q       <= '0;
         table_valid_q <= 1'b0;
         load_err_q    <= 1'b0;
         load_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         table_valid_q <= table_valid_d;
         load_err_q    <= load_err_d;
         load_done_q   <= load_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (entry_we) begin
         entry_q[count_q] <= wr_data;
      end
   end

   assign seg_idx     = IDX_W'(z__value[DATA_W-1 -: SEG_BITS]);
   assign seg_idx_nxt = seg_idx + IDX_W'(1);
   assign frac        = z__value[FRAC_W-1:0];
   assign lookup_fire = in_valid && table_valid_q;

   act_interp_pipe #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) u_interp (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (load_start),
      .in_valid_i  (lookup_fire),
      .base_i      (entry_q[seg_idx]),
      .next_i      (entry_q[seg_idx_nxt]),
      .frac_i      (frac),
      .out_valid_o (out_valid),
      .a_o         (a)
   );

   assign load_done   = load_done_q;
   assign load_err    = load_err_q;
   assign table_valid = table_valid_q;
endmodule

// File: tb/tb_act_lut_loader.sv
// Scoreboard bench for act_lut_loader: stimulus pushes expected activations,
// a negedge monitor pops and compares them as out_valid appears.
module tb_act_lut_loader;
   localparam int DW = 8;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 load_start = 1'b0;
   logic                 wr_valid = 1'b0;
   logic                 wr_last = 1'b0;
   logic                 in_valid = 1'b0;
   logic signed [DW-1:0] wr_data = '0;
   logic signed [DW-1:0] z__value = '0;
   logic                 wr_ready, load_done, load_err, table_valid, out_valid;
   logic signed [DW-1:0] a;

   act_lut_loader #(.DATA_W(8), .SEG_BITS(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_start  (load_start),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_data     (wr_data),
      .wr_last     (wr_last),
      .load_done   (load_done),
      .load_err    (load_err),
      .table_valid (table_valid),
      .in_valid    (in_valid),
      .z__value    (z__value),
      .out_valid   (out_valid),
      .a           (a)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a;
      int cyc;
      int z;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   tab[17];
   int   ld_val[17];
   bit   model_valid = 1'b0;
   bit   hold_en = 1'b0;
   int   cyc = 0;
   int   n_tot = 0;
   int   n_pass = 0;
   int   out_cnt = 0;
   int   last_a = 0;
   int   oc;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Monitor: every out_valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_a = 0;
      end else if (out_valid) begin
         out_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk($sformatf("a(z=0x%02h)", mon_e.z), int'(a), mon_e.a);
            chk("latency", cyc - mon_e.cyc, 2);
         end
         last_a = int'(a);
      end else if (hold_en) begin
         chk("a_hold", int'(a), last_a);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: straight-line interpolation between neighbouring entries, floored.
   function automatic int ref_a(input int z);
      int seg = (z >> 4) & 15;
      int r   = z & 15;
      int b   = tab[seg];
      int n   = tab[seg + 1];
      int p   = (n - b) * r;
      int q   = (p >= 0) ? (p / 16) : -((-p + 15) / 16);
      return b + q;
   endfunction

   task automatic push_exp(input int z, input int ea);
      exp_t e;
      e.a = ea;
      e.cyc = cyc;
      e.z = z;
      exp_q.push_back(e);
   endtask

   task automatic issue(input int z);
      in_valid = 1'b1;
      z__value = 8'(z);
      if (model_valid) push_exp(z, ref_a(z));
      tick();
   endtask

   task automatic issue_k(input int z, input int ea);
      in_valid = 1'b1;
      z__value = 8'(z);
      push_exp(z, ea);
      tick();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   // Results not yet presented when load_start is sampled are lost.
   task automatic start_load();
      load_start = 1'b1;
      model_valid = 1'b0;
      while (exp_q.size() > 0 && exp_q[$].cyc + 2 > cyc) void'(exp_q.pop_back());
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_beats(input int nbeats, input int last_at, input bit gaps);
      for (int i = 0; i < nbeats; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
               wr_valid = 1'b0;
               tick();
            end
         end
         chk("wr_ready_in_load", int'(wr_ready), 1);
         wr_valid = 1'b1;
         wr_data = 8'(ld_val[i]);
         wr_last = (i == last_at);
         tick();
      end
      wr_valid = 1'b0;
      wr_last = 1'b0;
   endtask

   task automatic good_load(input bit gaps);
      start_load();
      send_beats(17, 16, gaps);
      chk("load_done", int'(load_done), 1);
      chk("table_valid_after_load", int'(table_valid), 1);
      chk("load_err_after_load", int'(load_err), 0);
      chk("wr_ready_after_load", int'(wr_ready), 0);
      for (int i = 0; i < 17; i++) tab[i] = ld_val[i];
      model_valid = 1'b1;
      tick();
      chk("load_done_one_cycle", int'(load_done), 0);
   endtask

   task automatic random_lookups(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 2) == 0) idle(1);
         issue(int'($urandom_range(0, 255)));
      end
      idle(3);
   endtask

   initial begin
      // reset state
      repeat (2) tick();
      chk("rst_wr_ready", int'(wr_ready), 0);
      chk("rst_load_done", int'(load_done), 0);
      chk("rst_load_err", int'(load_err), 0);
      chk("rst_table_valid", int'(table_valid), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_a", int'(a), 0);
      rst_n = 1'b1;
      hold_en = 1'b1;
      tick();

      // ramp table entry[i] = 4*i
      for (int i = 0; i < 17; i++) ld_val[i] = 4 * i;
      good_load(1'b0);
      issue_k(8'h25, 9);
      idle(3);
      issue_k(8'hF0, 60);
      idle(3);

      // falling segment and full-range segment
      ld_val[3] = 10;
      ld_val[4] = 0;
      good_load(1'b1);
      issue_k(8'h38, 5);
      idle(3);
      ld_val[3] = 127;
      ld_val[4] = -128;
      good_load(1'b0);
      issue_k(8'h3F, -113);
      idle(3);

      // four back-to-back lookups
      oc = out_cnt;
      issue(8'h10);
      issue(8'h25);
      issue(8'h3F);
      issue(8'hF0);
      idle(3);
      chk("burst_out_count", out_cnt - oc, 4);

      // load_start mid-stream flushes the pipeline
      issue(8'h11);
      issue(8'h22);
      z__value = 8'h33;
      start_load();
      in_valid = 1'b0;
      oc = out_cnt;
      idle(4);
      chk("no_out_after_flush", out_cnt - oc, 0);

      // early wr_last on beat 5
      for (int i = 0; i < 17; i++) ld_val[i] = int'($urandom_range(0, 255)) - 128;
      send_beats(6, 5, 1'b0);
      chk("early_last_err", int'(load_err), 1);
      chk("early_last_table_valid", int'(table_valid), 0);
      chk("early_last_idle", int'(wr_ready), 0);
      chk("early_last_no_done", int'(load_done), 0);
      oc = out_cnt;
      issue(8'h25);
      idle(4);
      chk("no_out_without_table", out_cnt - oc, 0);
      chk("err_sticky", int'(load_err), 1);

      // beat 16 without wr_last
      start_load();
      chk("load_start_clears_err", int'(load_err), 0);
      send_beats(17, -1, 1'b1);
      chk("missing_last_err", int'(load_err), 1);
      chk("missing_last_table_valid", int'(table_valid), 0);
      chk("missing_last_no_done", int'(load_done), 0);

      // randomized tables and lookups
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 17; i++) ld_val[i] = int'($urandom_range(0, 255)) - 128;
         good_load(1'b1);
         random_lookups(30);
      end

      // reset while beat 8 is offered
      for (int i = 0; i < 17; i++) ld_val[i] = 16 * (i % 8) - 64;
      start_load();
      send_beats(8, -1, 1'b0);
      wr_valid = 1'b1;
      wr_data = 8'(ld_val[8]);
      rst_n = 1'b0;
      model_valid = 1'b0;
      exp_q.delete();
      tick();
      chk("rst_mid_wr_ready", int'(wr_ready), 0);
      chk("rst_mid_table_valid", int'(table_valid), 0);
      chk("rst_mid_load_done", int'(load_done), 0);
      chk("rst_mid_a", int'(a), 0);
      wr_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_no_done", int'(load_done), 0);
      chk("post_rst_idle", int'(wr_ready), 0);
      oc = out_cnt;
      issue(8'h40);
      idle(4);
      chk("no_out_after_rst", out_cnt - oc, 0);

      // a fresh load works again
      for (int i = 0; i < 17; i++) ld_val[i] = int'($urandom_range(0, 255)) - 128;
      good_load(1'b0);
      random_lookups(20);

      idle(3);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/act_lut_loader.md
ACT_LUT_LOADER -- requirements
Module: act_lut_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the width of table entries, z__value and a.
REQ-002 SHALL have parameter SEG_BITS, default 4, meaning the number of z__value MSBs used as the segment address (2**SEG_BITS segments, 2**SEG_BITS+1 entries).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset; it is synchronous and active-low.
REQ-005 SHALL have port load_start, input, 1, a pulse that begins a table load.
REQ-006 SHALL have port wr_valid, input, 1, meaning a write beat is offered.
REQ-007 SHALL have port wr_ready, output, 1, meaning the block accepts the beat.
REQ-008 SHALL have port wr_data, input, DATA_W, the signed table entry.
REQ-009 SHALL have port wr_last, input, 1, marking the final beat.
REQ-010 SHALL have port load_done, output, 1, a one-cycle pulse on successful load.
REQ-011 SHALL have port load_err, output, 1, a sticky error flag.
REQ-012 SHALL have port table_valid, output, 1, meaning the table is loaded and lookups are enabled.
REQ-013 SHALL have port in_valid, input, 1, the lookup request strobe.
REQ-014 SHALL have port z__value, input, DATA_W, the signed pre-activation value.
REQ-015 SHALL have port out_valid, output, 1, the result strobe.
REQ-016 SHALL have port a, output, DATA_W, the signed interpolated activation.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD and READY.
REQ-018 SHALL, on load_start in any state, enter LOAD, clear the beat counter and table_valid, set load_err to 0, and flush in-flight lookups.
REQ-019 SHALL drive wr_ready=1 only in LOAD; a beat transfers when wr_valid and wr_ready are both 1, writes entry[count], and increments count.
REQ-020 SHALL treat the transfer of beat 16 (count==2**SEG_BITS) with wr_last=1 as success: go to READY, set table_valid=1, pulse load_done for one cycle.
REQ-021 SHALL go to IDLE with load_err=1 and table_valid=0 when wr_last=1 on an earlier beat, or when wr_last=0 on beat 16.
REQ-022 SHALL give load_start priority over a simultaneous beat; that beat is discarded.
REQ-023 SHALL ignore in_valid unless table_valid=1; out_valid SHALL then stay 0.
REQ-024 SHALL compute the lookup as follows: address=z__value[7:4] unsigned, remaining=z__value[3:0] unsigned, base=entry[address], next__data=entry[address+1].
REQ-025 SHALL compute a = base + floor(((next__data-base)*remaining)/16), with the difference 9-bit signed, the product 13-bit signed and an arithmetic shift right by 4; the result always fits DATA_W, so no saturation is needed.
REQ-026 SHALL use a 2-stage pipeline: stage 1 registers base, difference and remaining; stage 2 registers a and out_valid.
REQ-027 SHALL deliver the result 2 cycles after in_valid, at a throughput of one lookup per cycle with no stalls.
REQ-028 SHALL hold a at its last value when out_valid=0.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge, set: state IDLE, count 0, wr_ready 0, load_done 0, load_err 0, table_valid 0, out_valid 0, a 0, all pipeline valids 0.
REQ-030 SHALL keep table entries unchanged on reset; they are unusable until a new successful load.
REQ-031 SHALL abort a load or lookup in progress at reset with no output pulse.

Structure
REQ-032 SHALL put DATA_W, SEG_BITS, the entry count and the FSM state enum in the shared activation package.
REQ-033 SHALL have one sub-module, act_interp_pipe, holding the 2-stage interpolation datapath; the loader FSM and the table registers stay in the top level.

Verification
REQ-034 SHALL cover: load entry[i]=4*i for i=0..16 with wr_last on beat 16 -> load_done pulse, table_valid=1, load_err=0.
REQ-035 SHALL cover: with that table, z__value=0x25 -> a=9 (8+floor(20/16)) with out_valid exactly 2 cycles later; z__value=0xF0 -> a=60.
REQ-036 SHALL cover: entry[3]=10 and entry[4]=0, z__value=0x38 -> a=5; entry[3]=127 and entry[4]=-128, z__value=0x3F -> a=-113.
REQ-037 SHALL cover: wr_last on beat 5 -> load_err=1, table_valid=0, state IDLE; a following in_valid -> no out_valid.
REQ-038 SHALL cover: back-to-back in_valid on 4 cycles -> 4 consecutive out_valid; load_start mid-stream -> no further out_valid.
REQ-039 SHALL cover: rst_n=0 during LOAD at beat 8 -> wr_ready=0, table_valid=0, no load_done.
